pcie_status_regs_v3: RTL and testbench



---
 rtl/pcie_status_pkg.sv | 19 +
 rtl/pcie_status_regs_v3_if.sv | 38 +++
 rtl/pcie_status_strb_reg.sv | 24 ++
 rtl/pcie_status_regs_v3.sv | 227 ++++++++++++++++++++++
 tb/tb_pcie_status_regs_v3.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcie_status_pkg.sv
// Shared types and constants for the pcie_status_regs_v3 AXI4-Lite register bank.
// Register-map index helpers keep the EVENT/MASK placement in one place.
package pcie_status_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  function automatic int event_idx(input int num_ctrl, input int num_stat);
    return num_ctrl + num_stat;
  endfunction

  function automatic int mask_idx(input int num_ctrl, input int num_stat);
    return num_ctrl + num_stat + 1;
  endfunction

endpackage

// File: rtl/pcie_status_regs_v3_if.sv
// AXI4-Lite channel bundle between the host interconnect (master) and the
// status register bank (slave).
interface pcie_status_regs_v3_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/pcie_status_strb_reg.sv
// One DATA_WIDTH register with per-byte write enable; used for the control
// registers and the interrupt MASK register.
module pcie_status_strb_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wstrb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/pcie_status_regs_v3.sv
// AXI4-Lite register bank: NUM_CTRL RW control, NUM_STAT RO status, one W1C EVENT.
// Optional MASK register and irq output when PCIE_STATUS_IRQ_EN is defined.
//
// state  | meaning
// W_IDLE | accepting AW and W beats independently, write applied once both held
// W_RESP | write applied, BVALID high until BREADY
// R_IDLE | ARREADY high, read data captured on the AR handshake
// R_DATA | RVALID high, RDATA/RRESP frozen until RREADY
module pcie_status_regs_v3
  import pcie_status_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CTRL   = 4,
  parameter int NUM_STAT   = 4,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  pcie_status_regs_v3_if.slave             s_axi,
  output logic [NUM_CTRL*DATA_WIDTH-1:0]   ctrl_out,
  input  logic [NUM_STAT*DATA_WIDTH-1:0]   status_in,
  input  logic [DATA_WIDTH-1:0]            event_in
`ifdef PCIE_STATUS_IRQ_EN
  ,
  output logic                             irq
`endif
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int ADDR_LSB  = $clog2(NUM_BYTES);
  localparam logic [ADDR_WIDTH-1:0] EV_IDX = ADDR_WIDTH'(event_idx(NUM_CTRL, NUM_STAT));
`ifdef PCIE_STATUS_IRQ_EN
  localparam logic [ADDR_WIDTH-1:0] MASK_IDX = ADDR_WIDTH'(mask_idx(NUM_CTRL, NUM_STAT));
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = MASK_IDX;
`else
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = EV_IDX;
`endif

  wr_state_t               wr_state, wr_state_nxt;
  logic                    aw_held, aw_held_nxt, w_held, w_held_nxt;
  logic                    aw_hs, w_hs, wr_fire;
  logic [ADDR_WIDTH-1:0]   awaddr_q, wr_addr, wr_idx;
  logic [DATA_WIDTH-1:0]   wdata_q, wr_data, wr_bitmask;
  logic [NUM_BYTES-1:0]    wstrb_q, wr_strb;
  logic [1:0]              bresp_q;

  rd_state_t               rd_state, rd_state_nxt;
  logic                    ar_hs;
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic [DATA_WIDTH-1:0]   rdata_nxt, rdata_q;
  logic [1:0]              rresp_nxt, rresp_q;

  logic [DATA_WIDTH-1:0]   ctrl_q [NUM_CTRL];
  logic [DATA_WIDTH-1:0]   ev_q, ev_clr;

  // A beat captured earlier wins over whatever is currently on the bus.
  always_comb begin
    wr_addr = aw_held ? awaddr_q : s_axi.S_AXI_AWADDR;
    wr_data = w_held  ? wdata_q  : s_axi.S_AXI_WDATA;
    wr_strb = w_held  ? wstrb_q  : s_axi.S_AXI_WSTRB;
    wr_idx  = wr_addr >> ADDR_LSB;
    wr_bitmask = '0;
    for (int b = 0; b < NUM_BYTES; b++) wr_bitmask[b*8 +: 8] = {8{wr_strb[b]}};
  end

  always_comb begin
    wr_state_nxt         = wr_state;
    aw_held_nxt          = aw_held;
    w_held_nxt           = w_held;
    aw_hs                = 1'b0;
    w_hs                 = 1'b0;
    wr_fire              = 1'b0;
    s_axi.S_AXI_AWREADY  = 1'b0;
    s_axi.S_AXI_WREADY   = 1'b0;
    s_axi.S_AXI_BVALID   = 1'b0;
    case (wr_state)
      W_IDLE: begin
        s_axi.S_AXI_AWREADY = !aw_held;
        s_axi.S_AXI_WREADY  = !w_held;
        aw_hs = !aw_held && s_axi.S_AXI_AWVALID;
        w_hs  = !w_held  && s_axi.S_AXI_WVALID;
        if ((aw_held || aw_hs) && (w_held || w_hs)) begin
          wr_fire      = 1'b1;
          aw_held_nxt  = 1'b0;
          w_held_nxt   = 1'b0;
          wr_state_nxt = W_RESP;
        end else begin
          aw_held_nxt = aw_held || aw_hs;
          w_held_nxt  = w_held  || w_hs;
        end
      end
      W_RESP: begin
        s_axi.S_AXI_BVALID = 1'b1;
        if (s_axi.S_AXI_BREADY) wr_state_nxt = W_IDLE;
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state <= W_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      wr_state <= wr_state_nxt;
      aw_held  <= aw_held_nxt;
      w_held   <= w_held_nxt;
      if (aw_hs) awaddr_q <= s_axi.S_AXI_AWADDR;
      if (w_hs) begin
        wdata_q <= s_axi.S_AXI_WDATA;
        wstrb_q <= s_axi.S_AXI_WSTRB;
      end
      // Status writes are silently accepted; only indices past the map error.
      if (wr_fire) bresp_q <= (wr_idx <= LAST_IDX) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign s_axi.S_AXI_BRESP = bresp_q;

  for (genvar k = 0; k < NUM_CTRL; k++) begin : g_ctrl
    pcie_status_strb_reg #(.DATA_WIDTH(DATA_WIDTH)) u_ctrl_reg (
      .clk   (ACLK),
      .rst   (ARESET),
      .we    (wr_fire && (wr_idx == ADDR_WIDTH'(k))),
      .wstrb (wr_strb),
      .wdata (wr_data),
      .q     (ctrl_q[k])
    );
    assign ctrl_out[k*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[k];
  end

  // New events are OR-ed in after the clear so a coincident pulse survives.
  assign ev_clr = (wr_fire && (wr_idx == EV_IDX)) ? (wr_data & wr_bitmask) : '0;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) ev_q <= '0;
    else        ev_q <= (ev_q & ~ev_clr) | event_in;
  end

`ifdef PCIE_STATUS_IRQ_EN
  logic [DATA_WIDTH-1:0] mask_q;

  pcie_status_strb_reg #(.DATA_WIDTH(DATA_WIDTH)) u_mask_reg (
    .clk   (ACLK),
    .rst   (ARESET),
    .we    (wr_fire && (wr_idx == MASK_IDX)),
    .wstrb (wr_strb),
    .wdata (wr_data),
    .q     (mask_q)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) irq <= 1'b0;
    else        irq <= |(ev_q & mask_q);
  end
`endif

  always_comb begin
    rd_idx    = s_axi.S_AXI_ARADDR >> ADDR_LSB;
    rdata_nxt = '0;
    rresp_nxt = RESP_SLVERR;
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (rd_idx == ADDR_WIDTH'(k)) begin
        rdata_nxt = ctrl_q[k];
        rresp_nxt = RESP_OKAY;
      end
    end
    for (int k = 0; k < NUM_STAT; k++) begin
      if (rd_idx == ADDR_WIDTH'(NUM_CTRL + k)) begin
        rdata_nxt = status_in[k*DATA_WIDTH +: DATA_WIDTH];
        rresp_nxt = RESP_OKAY;
      end
    end
    if (rd_idx == EV_IDX) begin
      rdata_nxt = ev_q;
      rresp_nxt = RESP_OKAY;
    end
`ifdef PCIE_STATUS_IRQ_EN
    if (rd_idx == MASK_IDX) begin
      rdata_nxt = mask_q;
      rresp_nxt = RESP_OKAY;
    end
`endif
  end

  always_comb begin
    rd_state_nxt        = rd_state;
    ar_hs               = 1'b0;
    s_axi.S_AXI_ARREADY = 1'b0;
    s_axi.S_AXI_RVALID  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        s_axi.S_AXI_ARREADY = 1'b1;
        ar_hs = s_axi.S_AXI_ARVALID;
        if (ar_hs) rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        s_axi.S_AXI_RVALID = 1'b1;
        if (s_axi.S_AXI_RREADY) rd_state_nxt = R_IDLE;
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rd_state <= rd_state_nxt;
      if (ar_hs) begin
        rdata_q <= rdata_nxt;
        rresp_q <= rresp_nxt;
      end
    end
  end

  assign s_axi.S_AXI_RDATA = rdata_q;
  assign s_axi.S_AXI_RRESP = rresp_q;

endmodule

// File: tb/tb_pcie_status_regs_v3.sv
// Directed bench for pcie_status_regs_v3 (default parameters); irq checks are
// enabled when PCIE_STATUS_IRQ_EN is defined.
module tb_pcie_status_regs_v3;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [127:0]  ctrl_out;
  logic [127:0]  status_in;
  logic [31:0]   event_in;
`ifdef PCIE_STATUS_IRQ_EN
  logic          irq;
`endif

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] rd;
  logic [1:0]  rsp;

  pcie_status_regs_v3_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) axi ();

  pcie_status_regs_v3 #(
    .DATA_WIDTH(32), .NUM_CTRL(4), .NUM_STAT(4), .ADDR_WIDTH(8)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .s_axi     (axi.slave),
    .ctrl_out  (ctrl_out),
    .status_in (status_in),
    .event_in  (event_in)
`ifdef PCIE_STATUS_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_go, w_go, got = 0;
    int n = 0;
    axi.S_AXI_AWADDR = addr; axi.S_AXI_WDATA = data; axi.S_AXI_WSTRB = strb;
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge ACLK);
      aw_go = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      w_go  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (aw_go) begin aw_done = 1; axi.S_AXI_AWVALID = 1'b0; end
      if (w_go)  begin w_done = 1;  axi.S_AXI_WVALID  = 1'b0; end
      n++;
    end
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
    check("wr_addr_data_accepted", 64'(aw_done && w_done), 64'd1);
    axi.S_AXI_BREADY = 1'b1;
    resp = 2'bxx; n = 0;
    while (!got && n < 20) begin
      @(negedge ACLK);
      if (axi.S_AXI_BVALID) begin resp = axi.S_AXI_BRESP; got = 1; end
      @(posedge ACLK); #1;
      n++;
    end
    axi.S_AXI_BREADY = 1'b0;
    check("wr_resp_seen", 64'(got), 64'd1);
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ar_done = 0, ar_go, got = 0;
    int n = 0;
    axi.S_AXI_ARADDR = addr; axi.S_AXI_ARVALID = 1'b1;
    while (!ar_done && n < 20) begin
      @(negedge ACLK);
      ar_go = axi.S_AXI_ARREADY;
      @(posedge ACLK); #1;
      if (ar_go) begin ar_done = 1; axi.S_AXI_ARVALID = 1'b0; end
      n++;
    end
    axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY = 1'b1;
    data = 'x; resp = 2'bxx; n = 0;
    while (!got && n < 20) begin
      @(negedge ACLK);
      if (axi.S_AXI_RVALID) begin data = axi.S_AXI_RDATA; resp = axi.S_AXI_RRESP; got = 1; end
      @(posedge ACLK); #1;
      n++;
    end
    axi.S_AXI_RREADY = 1'b0;
    check("rd_data_seen", 64'(got), 64'd1);
  endtask

  initial begin
    ARESET = 1'b1;
    status_in = '0; event_in = '0;
    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WDATA = '0;
    axi.S_AXI_WSTRB = '0; axi.S_AXI_WVALID = 1'b0; axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_ARADDR = '0; axi.S_AXI_ARVALID = 1'b0; axi.S_AXI_RREADY = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;

    // reset state
    @(negedge ACLK);
    check("rst_ctrl_out", ctrl_out, 0);
    check("rst_bvalid", axi.S_AXI_BVALID, 0);
    check("rst_rvalid", axi.S_AXI_RVALID, 0);
    check("rst_awready", axi.S_AXI_AWREADY, 1);
    check("rst_wready", axi.S_AXI_WREADY, 1);
    check("rst_arready", axi.S_AXI_ARREADY, 1);
`ifdef PCIE_STATUS_IRQ_EN
    check("rst_irq", irq, 0);
`endif
    @(posedge ACLK); #1;

    // control register write/readback
    for (int i = 0; i < 4; i++) begin
      axi_write(8'(i*4), 32'(i+1), 4'hF, rsp);
      check("ctrl_wr_bresp", rsp, 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(8'(i*4), rd, rsp);
      check("ctrl_rd_data", rd, 32'(i+1));
      check("ctrl_rd_rresp", rsp, 2'b00);
      check("ctrl_out_slice", ctrl_out[i*32 +: 32], 32'(i+1));
    end

    // byte strobes
    axi_write(8'h00, 32'hAABBCCDD, 4'hF, rsp);
    axi_write(8'h00, 32'h00001100, 4'b0010, rsp);
    axi_read(8'h00, rd, rsp);
    check("strb_merge", rd, 32'hAABB11DD);
    axi_read(8'h02, rd, rsp);
    check("low_addr_bits_ignored", rd, 32'hAABB11DD);

    // W three cycles ahead of AW, BREADY held low for 5 cycles
    axi.S_AXI_WDATA = 32'h12345678; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1 axi.S_AXI_WVALID = 1'b0;
    repeat (2) begin
      @(negedge ACLK);
      check("w_first_wready_low", axi.S_AXI_WREADY, 0);
      check("w_first_awready_high", axi.S_AXI_AWREADY, 1);
      check("w_first_no_bvalid", axi.S_AXI_BVALID, 0);
      @(posedge ACLK); #1;
    end
    axi.S_AXI_AWADDR = 8'h04; axi.S_AXI_AWVALID = 1'b1;
    @(posedge ACLK); #1 axi.S_AXI_AWVALID = 1'b0;
    check("w_first_ctrl_out", ctrl_out[63:32], 32'h12345678);
    repeat (5) begin
      @(negedge ACLK);
      check("b_hold_bvalid", axi.S_AXI_BVALID, 1);
      check("b_hold_awready", axi.S_AXI_AWREADY, 0);
      check("b_hold_wready", axi.S_AXI_WREADY, 0);
      @(posedge ACLK); #1;
    end
    axi.S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1 axi.S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    check("b_done_bvalid", axi.S_AXI_BVALID, 0);
    check("b_done_awready", axi.S_AXI_AWREADY, 1);
    check("b_done_wready", axi.S_AXI_WREADY, 1);
    @(posedge ACLK); #1;
    axi_read(8'h04, rd, rsp);
    check("w_first_readback", rd, 32'h12345678);

    // status, unmapped
    status_in[31:0] = 32'hDEADBEEF; status_in[63:32] = 32'h0000CAFE;
    axi_read(8'h10, rd, rsp);
    check("stat0_data", rd, 32'hDEADBEEF);
    check("stat0_rresp", rsp, 2'b00);
    axi_read(8'h14, rd, rsp);
    check("stat1_data", rd, 32'h0000CAFE);
    axi_write(8'h10, 32'h0, 4'hF, rsp);
    check("stat_wr_bresp", rsp, 2'b00);
    axi_read(8'h10, rd, rsp);
    check("stat_wr_ignored", rd, 32'hDEADBEEF);
    axi_read(8'hF0, rd, rsp);
    check("unmapped_rd_data", rd, 0);
    check("unmapped_rd_rresp", rsp, 2'b10);
    axi_write(8'hF0, 32'hFFFFFFFF, 4'hF, rsp);
    check("unmapped_wr_bresp", rsp, 2'b10);
    check("unmapped_wr_no_effect", ctrl_out, {32'h4, 32'h3, 32'h12345678, 32'hAABB11DD});
`ifndef PCIE_STATUS_IRQ_EN
    axi_read(8'h24, rd, rsp);
    check("mask_unmapped_rresp", rsp, 2'b10);
`endif

    // EVENT W1C
    event_in = 32'h5;
    @(posedge ACLK); #1 event_in = '0;
    axi_read(8'h20, rd, rsp);
    check("event_set", rd, 32'h5);
    axi.S_AXI_AWADDR = 8'h20; axi.S_AXI_WDATA = 32'h1; axi.S_AXI_WSTRB = 4'hF;
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1; event_in = 32'h1;
    @(posedge ACLK); #1;
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0; event_in = '0;
    axi.S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    check("ev_setwin_bvalid", axi.S_AXI_BVALID, 1);
    @(posedge ACLK); #1 axi.S_AXI_BREADY = 1'b0;
    axi_read(8'h20, rd, rsp);
    check("event_set_wins", rd, 32'h5);
    axi_write(8'h20, 32'h5, 4'hF, rsp);
    check("event_clr_bresp", rsp, 2'b00);
    axi_read(8'h20, rd, rsp);
    check("event_cleared", rd, 32'h0);

    // same-cycle read and write of ctrl0 returns the old value
    axi.S_AXI_AWADDR = 8'h00; axi.S_AXI_WDATA = 32'h55; axi.S_AXI_WSTRB = 4'hF;
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
    axi.S_AXI_ARADDR = 8'h00; axi.S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0; axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_BREADY = 1'b1; axi.S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    check("rw_same_rvalid", axi.S_AXI_RVALID, 1);
    check("rw_same_old_value", axi.S_AXI_RDATA, 32'hAABB11DD);
    check("rw_same_bvalid", axi.S_AXI_BVALID, 1);
    @(posedge ACLK); #1;
    axi.S_AXI_BREADY = 1'b0; axi.S_AXI_RREADY = 1'b0;
    axi_read(8'h00, rd, rsp);
    check("rw_same_new_value", rd, 32'h55);

`ifdef PCIE_STATUS_IRQ_EN
    axi_write(8'h24, 32'h4, 4'hF, rsp);
    check("mask_wr_bresp", rsp, 2'b00);
    axi_read(8'h24, rd, rsp);
    check("mask_readback", rd, 32'h4);
    event_in = 32'h1;
    @(posedge ACLK); #1 event_in = '0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check("irq_masked_bit", irq, 0);
    @(posedge ACLK); #1;
    axi_write(8'h20, 32'h1, 4'hF, rsp);
    event_in = 32'h4;
    @(posedge ACLK); #1 event_in = '0;
    @(negedge ACLK);
    check("irq_lag_cycle", irq, 0);
    @(negedge ACLK);
    check("irq_set", irq, 1);
    @(posedge ACLK); #1;
    axi_write(8'h20, 32'h4, 4'hF, rsp);
    @(negedge ACLK);
    check("irq_cleared", irq, 0);
    @(posedge ACLK); #1;
    event_in = 32'h4;
    @(posedge ACLK); #1 event_in = '0;
    @(posedge ACLK); #1;
`endif

    // reset while read and write responses are pending
    axi.S_AXI_AWADDR = 8'h08; axi.S_AXI_WDATA = 32'h77; axi.S_AXI_WSTRB = 4'hF;
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
    axi.S_AXI_ARADDR = 8'h10; axi.S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0; axi.S_AXI_ARVALID = 1'b0;
    status_in[31:0] = 32'h0BADF00D;
    @(negedge ACLK);
    check("pend_bvalid", axi.S_AXI_BVALID, 1);
    check("pend_rvalid", axi.S_AXI_RVALID, 1);
    check("pend_ctrl2", ctrl_out[95:64], 32'h77);
    @(negedge ACLK);
    check("rdata_held", axi.S_AXI_RDATA, 32'hDEADBEEF);
    check("rvalid_held", axi.S_AXI_RVALID, 1);
`ifdef PCIE_STATUS_IRQ_EN
    check("irq_before_rst", irq, 1);
`endif
    #2 ARESET = 1'b1;
    #1;
    check("midrst_rvalid", axi.S_AXI_RVALID, 0);
    check("midrst_bvalid", axi.S_AXI_BVALID, 0);
    check("midrst_ctrl_out", ctrl_out, 0);
`ifdef PCIE_STATUS_IRQ_EN
    check("midrst_irq", irq, 0);
`endif
    @(posedge ACLK); #1 ARESET = 1'b0;
    axi_read(8'h20, rd, rsp);
    check("post_rst_event", rd, 0);
    axi_read(8'h04, rd, rsp);
    check("post_rst_ctrl1", rd, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
